adma_atx_split: RTL and testbench

//  Multi-burst AXI transaction generator for the DMA engine. Accepts one DMA

---
 rtl/adma_atx_split.sv | 213 +++++++++++++++++++++
 tb/tb_adma_atx_split.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adma_atx_split.sv
// adma_atx_split
//   Splits one DMA transaction (src, dst, beat count) into a stream of AXI
//   AR/AW burst descriptors. Each burst is limited by the remaining beats,
//   the per-burst word cap, the AXI len range and the 2^BOUNDARY_W-byte page
//   of every INCR side. One descriptor is issued per atx_vld/atx_rdy handshake.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   tx_src_addr/tx_dst_addr   transaction start addresses (beat-aligned)
//   tx_len                    transaction beats minus one
//   tx_vld/tx_rdy             transaction handshake
//   atx_id                    ID for all bursts of the transaction
//   atx_src_burst/dst_burst   burst types (01 INCR, anything else FIXED)
//   atx_wd_per_burst          max beats per burst minus one
//   arid/awid, araddr/awaddr, arlen/awlen, arburst/awburst
//                             burst descriptor payload
//   atx_vld/atx_rdy           descriptor handshake
//   atx_last                  descriptor is last of the transaction
//   atx_start/atx_start_last  descriptor handshake / last-descriptor handshake
//   busy                      transaction in progress
module adma_atx_split #(
  parameter int unsigned SRC_ADDR_W   = 32,
  parameter int unsigned DST_ADDR_W   = 32,
  parameter int unsigned DMA_LENGTH_W = 16,
  parameter int unsigned MST_ID_W     = 5,
  parameter int unsigned ATX_LEN_W    = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BOUNDARY_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SRC_ADDR_W-1:0]   tx_src_addr,
  input  logic [DST_ADDR_W-1:0]   tx_dst_addr,
  input  logic [DMA_LENGTH_W-1:0] tx_len,
  input  logic                    tx_vld,
  output logic                    tx_rdy,
  input  logic [MST_ID_W-1:0]     atx_id,
  input  logic [1:0]              atx_src_burst,
  input  logic [1:0]              atx_dst_burst,
  input  logic [DMA_LENGTH_W-1:0] atx_wd_per_burst,
  output logic [MST_ID_W-1:0]     arid,
  output logic [SRC_ADDR_W-1:0]   araddr,
  output logic [ATX_LEN_W-1:0]    arlen,
  output logic [1:0]              arburst,
  output logic [MST_ID_W-1:0]     awid,
  output logic [DST_ADDR_W-1:0]   awaddr,
  output logic [ATX_LEN_W-1:0]    awlen,
  output logic [1:0]              awburst,
  output logic                    atx_vld,
  input  logic                    atx_rdy,
  output logic                    atx_last,
  output logic                    atx_start,
  output logic                    atx_start_last,
  output logic                    busy
);

  localparam int unsigned SIZE = $clog2(DATA_W / 8);
  localparam int unsigned RW   = DMA_LENGTH_W + 1;
  localparam int unsigned CW0  = (RW > BOUNDARY_W + 1) ? RW : BOUNDARY_W + 1;
  localparam int unsigned CW   = (CW0 > ATX_LEN_W + 1) ? CW0 : ATX_LEN_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_t;

  state_t state, state_nxt;

  // Registered state of the descriptor currently presented
  logic [SRC_ADDR_W-1:0]   src_q;
  logic [DST_ADDR_W-1:0]   dst_q;
  logic [RW-1:0]           rem_q;
  logic [ATX_LEN_W:0]      cap_q;
  logic [MST_ID_W-1:0]     id_q;
  logic [1:0]              sburst_q;
  logic [1:0]              dburst_q;
  logic [ATX_LEN_W-1:0]    len_q;
  logic                    last_q;

  // Values for the next descriptor
  logic                    load;
  logic [SRC_ADDR_W-1:0]   ld_src;
  logic [DST_ADDR_W-1:0]   ld_dst;
  logic [RW-1:0]           ld_rem;
  logic [CW-1:0]           ld_cap;
  logic                    ld_sinc;
  logic                    ld_dinc;
  logic [CW-1:0]           cur_n;
  logic [CW-1:0]           n_nxt;
  logic [CW-1:0]           wd_c;
  logic [CW-1:0]           lmax_c;

  // Beats left until the end of the page holding the given offset.
  function automatic logic [CW-1:0] page_beats(input logic [BOUNDARY_W-1:0] off);
    logic [BOUNDARY_W:0] bytes;
    bytes = {1'b1, {BOUNDARY_W{1'b0}}} - {1'b0, off};
    return CW'(bytes >> SIZE);
  endfunction

  function automatic logic [CW-1:0] burst_beats(
    input logic [CW-1:0]         rem,
    input logic [CW-1:0]         cap,
    input logic [BOUNDARY_W-1:0] s_off,
    input logic [BOUNDARY_W-1:0] d_off,
    input logic                  s_inc,
    input logic                  d_inc
  );
    logic [CW-1:0] n;
    logic [CW-1:0] pb;
    n = rem;
    if (cap < n) n = cap;
    if (s_inc) begin
      pb = page_beats(s_off);
      if (pb < n) n = pb;
    end
    if (d_inc) begin
      pb = page_beats(d_off);
      if (pb < n) n = pb;
    end
    return n;
  endfunction

  assign atx_vld        = (state == ST_ISSUE);
  assign busy           = (state == ST_ISSUE);
  assign tx_rdy         = (state == ST_IDLE);
  assign atx_start      = atx_vld & atx_rdy;
  assign atx_start_last = atx_start & last_q;
  assign atx_last       = last_q;

  assign araddr  = src_q;
  assign awaddr  = dst_q;
  assign arlen   = len_q;
  assign awlen   = len_q;
  assign arid    = id_q;
  assign awid    = id_q;
  assign arburst = sburst_q;
  assign awburst = dburst_q;

  assign cur_n  = CW'(len_q) + CW'(1);
  assign wd_c   = CW'(atx_wd_per_burst);
  assign lmax_c = CW'({ATX_LEN_W{1'b1}});

  // The next descriptor's beat count is derived from the advanced (or freshly
  // accepted) state so it can be registered and presented one cycle later.
  always_comb begin
    load    = 1'b0;
    ld_src  = src_q;
    ld_dst  = dst_q;
    ld_rem  = rem_q;
    ld_cap  = CW'(cap_q);
    ld_sinc = (sburst_q == 2'b01);
    ld_dinc = (dburst_q == 2'b01);
    if (state == ST_IDLE) begin
      load    = tx_vld;
      ld_src  = tx_src_addr;
      ld_dst  = tx_dst_addr;
      ld_rem  = RW'(tx_len) + RW'(1);
      ld_cap  = ((wd_c > lmax_c) ? lmax_c : wd_c) + CW'(1);
      ld_sinc = (atx_src_burst == 2'b01);
      ld_dinc = (atx_dst_burst == 2'b01);
    end else begin
      load = atx_start & ~last_q;
      if (ld_sinc) ld_src = src_q + (SRC_ADDR_W'(cur_n) << SIZE);
      if (ld_dinc) ld_dst = dst_q + (DST_ADDR_W'(cur_n) << SIZE);
      ld_rem = rem_q - RW'(cur_n);
    end
    n_nxt = burst_beats(CW'(ld_rem), ld_cap, ld_src[BOUNDARY_W-1:0],
                        ld_dst[BOUNDARY_W-1:0], ld_sinc, ld_dinc);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tx_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: if (atx_start_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      cap_q    <= '0;
      id_q     <= '0;
      sburst_q <= '0;
      dburst_q <= '0;
      len_q    <= '0;
      last_q   <= 1'b0;
    end else if (load) begin
      src_q  <= ld_src;
      dst_q  <= ld_dst;
      rem_q  <= ld_rem;
      cap_q  <= ld_cap[ATX_LEN_W:0];
      len_q  <= ATX_LEN_W'(n_nxt - CW'(1));
      last_q <= (n_nxt == CW'(ld_rem));
      if (state == ST_IDLE) begin
        id_q     <= atx_id;
        sburst_q <= atx_src_burst;
        dburst_q <= atx_dst_burst;
      end
    end else if (atx_start_last) begin
      last_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adma_atx_split.sv
module tb_adma_atx_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tx_src_addr = '0;
  logic [31:0] tx_dst_addr = '0;
  logic [15:0] tx_len = '0;
  logic        tx_vld = 1'b0;
  logic        tx_rdy;
  logic [4:0]  atx_id = '0;
  logic [1:0]  atx_src_burst = '0;
  logic [1:0]  atx_dst_burst = '0;
  logic [15:0] atx_wd_per_burst = '0;
  logic [4:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic        atx_vld;
  logic        atx_rdy = 1'b0;
  logic        atx_last, atx_start, atx_start_last, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adma_atx_split #(
    .SRC_ADDR_W(32), .DST_ADDR_W(32), .DMA_LENGTH_W(16), .MST_ID_W(5),
    .ATX_LEN_W(8), .DATA_W(32), .BOUNDARY_W(12)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_src_addr(tx_src_addr), .tx_dst_addr(tx_dst_addr), .tx_len(tx_len),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy), .atx_id(atx_id),
    .atx_src_burst(atx_src_burst), .atx_dst_burst(atx_dst_burst),
    .atx_wd_per_burst(atx_wd_per_burst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .atx_last(atx_last),
    .atx_start(atx_start), .atx_start_last(atx_start_last), .busy(busy)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    int unsigned len;
    bit          last;
  } burst_t;

  burst_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the transaction beat budget, clipping each burst by
  // remaining beats, word cap, AXI len range and the 4KB page of INCR sides.
  function automatic void model(input logic [31:0] s, input logic [31:0] d,
                                input int unsigned len, input logic [1:0] sb,
                                input logic [1:0] db, input int unsigned wd);
    int unsigned rem, cap, n, page;
    logic [31:0] cs, cd;
    burst_t b;
    rem = len + 1;
    cap = ((wd > 255) ? 255 : wd) + 1;
    cs = s;
    cd = d;
    while (rem > 0) begin
      n = rem;
      if (cap < n) n = cap;
      if (sb == 2'b01) begin
        page = (4096 - (cs % 4096)) / 4;
        if (page < n) n = page;
      end
      if (db == 2'b01) begin
        page = (4096 - (cd % 4096)) / 4;
        if (page < n) n = page;
      end
      b.s = cs; b.d = cd; b.len = n - 1; b.last = (n == rem);
      exp_q.push_back(b);
      if (sb == 2'b01) cs = cs + n * 4;
      if (db == 2'b01) cd = cd + n * 4;
      rem = rem - n;
    end
  endfunction

  task automatic run_tx(input logic [31:0] s, input logic [31:0] d, input int unsigned len,
                        input logic [1:0] sb, input logic [1:0] db, input int unsigned wd,
                        input logic [4:0] id, input int rdy_pct, input int stall_at,
                        input int abort_at);
    int hs = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit holding = 0;
    bit aborted = 0;
    bit rdy;
    logic [31:0] h_a, h_w;
    logic [7:0]  h_l;
    logic        h_last;
    exp_q.delete();
    model(s, d, len, sb, db, wd);
    while (!tx_rdy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_rdy_idle", tx_rdy, 1);
    tx_src_addr = s; tx_dst_addr = d; tx_len = 16'(len);
    atx_src_burst = sb; atx_dst_burst = db; atx_wd_per_burst = 16'(wd);
    atx_id = id; tx_vld = 1'b1; atx_rdy = 1'b0;
    @(negedge clk);
    tx_vld = 1'b0;
    check("first_vld", atx_vld, 1);
    check("arid", arid, id);
    check("awid", awid, id);
    check("arburst", arburst, sb);
    check("awburst", awburst, db);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      if (hs == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_vld", atx_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_rdy", tx_rdy, 1);
        check("rst_last", atx_last, 0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      check("vld", atx_vld, 1);
      check("busy", busy, 1);
      check("tx_rdy_busy", tx_rdy, 0);
      if (holding) begin
        check("hold_araddr", araddr, h_a);
        check("hold_awaddr", awaddr, h_w);
        check("hold_arlen", arlen, h_l);
        check("hold_last", atx_last, h_last);
      end
      if (hs == stall_at && !stalled) begin
        stall_left = 5;
        stalled = 1;
      end
      if (stall_left > 0) begin
        rdy = 0;
        stall_left--;
      end else begin
        rdy = ($urandom % 100) < rdy_pct;
      end
      atx_rdy = rdy;
      #1;
      check("start", atx_start, rdy);
      check("start_last", atx_start_last, rdy & exp_q[0].last);
      if (rdy) begin
        check("araddr", araddr, exp_q[0].s);
        check("awaddr", awaddr, exp_q[0].d);
        check("arlen", arlen, exp_q[0].len);
        check("awlen", awlen, exp_q[0].len);
        check("last", atx_last, exp_q[0].last);
        void'(exp_q.pop_front());
        hs++;
        holding = 0;
      end else begin
        holding = 1;
        h_a = araddr; h_w = awaddr; h_l = arlen; h_last = atx_last;
      end
      @(negedge clk);
      cyc++;
    end
    atx_rdy = 1'b0;
    if (!aborted && exp_q.size() != 0) check("timeout", 1, 0);
    check("end_vld", atx_vld, 0);
    check("end_busy", busy, 0);
    check("end_tx_rdy", tx_rdy, 1);
  endtask

  initial begin
    logic [31:0] s, d;
    repeat (2) @(negedge clk);
    check("reset_vld", atx_vld, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_rdy", tx_rdy, 1);
    check("reset_last", atx_last, 0);
    check("reset_araddr", araddr, 0);
    check("reset_arlen", arlen, 0);
    rst = 1'b0;
    @(negedge clk);

    run_tx(32'h0, 32'h8000, 99, 2'b01, 2'b01, 15, 5'd3, 100, -1, -1);
    run_tx(32'h0FF0, 32'h2000, 7, 2'b01, 2'b01, 15, 5'd4, 100, -1, -1);
    run_tx(32'h100, 32'h0FF8, 3, 2'b00, 2'b01, 15, 5'd5, 100, -1, -1);
    run_tx(32'h0, 32'h2000, 511, 2'b01, 2'b01, 16'h3FF, 5'd6, 100, -1, -1);
    run_tx(32'h0, 32'h8000, 99, 2'b01, 2'b01, 15, 5'd7, 100, 2, -1);
    run_tx(32'hFFFF_FFF0, 32'h40, 7, 2'b01, 2'b10, 15, 5'd8, 100, -1, -1);
    run_tx(32'h0, 32'h8000, 99, 2'b01, 2'b01, 15, 5'd9, 100, -1, 2);
    run_tx(32'h0FF0, 32'h3000, 7, 2'b01, 2'b01, 15, 5'd10, 100, -1, -1);

    for (int i = 0; i < 30; i++) begin
      s = ($urandom % 2) ? ($urandom & 32'hFFFF_FFFC)
                         : (($urandom & 32'hFFFF_F000) - 4 * $urandom_range(0, 20));
      d = ($urandom % 2) ? ($urandom & 32'hFFFF_FFFC)
                         : (($urandom & 32'hFFFF_F000) - 4 * $urandom_range(0, 20));
      run_tx(s, d, $urandom_range(0, 300), 2'($urandom), 2'($urandom),
             ($urandom % 4 == 0) ? $urandom_range(256, 1023) : $urandom_range(0, 40),
             5'($urandom), 70, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
